// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: NM masters share one slave port.
// A grant lasts for the whole cyc; outstanding strobes are counted so acks only reach the owner.
module wb_arbiter #(
  parameter int unsigned NM      = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_cyc,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_adr,
  input  logic [NM*DW-1:0] m_dat_m,
  output logic [DW-1:0]    m_dat_s,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_stall,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [AW-1:0]    s_adr,
  output logic [DW-1:0]    s_dat_m,
  input  logic [DW-1:0]    s_dat_s,
  input  logic             s_ack,
  input  logic             s_stall,
  output logic [NM-1:0]    gnt
);

  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NM-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;  // in BUSY this is also the granted index
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic            accept;
  logic            retire;
  logic            cnt_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_full = (cnt_q == CW'(MAX_OUT));
  assign accept   = s_stb & ~s_stall;
  assign retire   = s_ack & (cnt_q != '0);

  // Next state: rotating-priority search from last+1, then outstanding-strobe tracking.
  always_comb begin
    int unsigned idx;
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    winner  = last_q;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NM; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NM) idx = idx - NM;
      if (!any_req && m_cyc[IW'(idx)]) begin
        any_req = 1'b1;
        winner  = IW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = NM'(1) << winner;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!m_cyc[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (accept && !retire) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!accept && retire) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: combinational pass-through of the granted master while BUSY.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_m = '0;
    m_ack   = '0;
    m_stall = '1;
    if (state_q == BUSY) begin
      s_cyc           = m_cyc[last_q];
      s_stb           = m_stb[last_q] & m_cyc[last_q] & ~cnt_full;
      s_we            = m_we[last_q];
      s_adr           = m_adr[32'(last_q)*AW +: AW];
      s_dat_m         = m_dat_m[32'(last_q)*DW +: DW];
      m_stall[last_q] = s_stall | cnt_full;
      m_ack[last_q]   = s_ack & m_cyc[last_q];
    end
  end

  assign m_dat_s = s_dat_s;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle ownership model checks every output at the
// falling edge, and literal expectations pin the model at the interesting cycles.
module tb_wb_arbiter;

  localparam int unsigned NM      = 2;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int          MAX_OUT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NM-1:0]    m_cyc = '0;
  logic [NM-1:0]    m_stb = '0;
  logic [NM-1:0]    m_we = '0;
  logic [NM*AW-1:0] m_adr = '0;
  logic [NM*DW-1:0] m_dat_m = '0;
  logic [DW-1:0]    m_dat_s;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_stall;
  logic             s_cyc;
  logic             s_stb;
  logic             s_we;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_m;
  logic [DW-1:0]    s_dat_s = 16'h5A5A;
  logic             s_ack = 1'b0;
  logic             s_stall = 1'b0;
  logic [NM-1:0]    gnt;

  int checks = 0;
  int errors = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int acc_cnt = 0;

  // Model state: who owns the slave (-1 = nobody), who owned it last, strobes awaiting ack.
  int owner = -1;
  int mlast = NM - 1;
  int mcnt  = 0;

  wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m(m_dat_m),
    .m_dat_s(m_dat_s), .m_ack(m_ack), .m_stall(m_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
    .s_dat_s(s_dat_s), .s_ack(s_ack), .s_stall(s_stall), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [NM-1:0] e_ack, e_stall, e_gnt;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    int            idx;
    if (!rst_n) begin
      owner = -1;
      mlast = NM - 1;
      mcnt  = 0;
    end
    e_ack = '0; e_stall = '1; e_gnt = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    if (owner >= 0) begin
      e_gnt[owner]   = 1'b1;
      e_cyc          = m_cyc[owner];
      e_stb          = m_stb[owner] && m_cyc[owner] && (mcnt < MAX_OUT);
      e_we           = m_we[owner];
      e_adr          = m_adr[owner*AW +: AW];
      e_dat          = m_dat_m[owner*DW +: DW];
      e_stall[owner] = s_stall || (mcnt == MAX_OUT);
      e_ack[owner]   = s_ack && m_cyc[owner];
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
    chk("s_stb", 32'(s_stb), 32'(e_stb));
    chk("s_we", 32'(s_we), 32'(e_we));
    chk("s_adr", 32'(s_adr), 32'(e_adr));
    chk("s_dat_m", 32'(s_dat_m), 32'(e_dat));
    chk("m_ack", 32'(m_ack), 32'(e_ack));
    chk("m_stall", 32'(m_stall), 32'(e_stall));
    chk("m_dat_s", 32'(m_dat_s), 32'(s_dat_s));
    if (m_ack[0]) ack0_cnt++;
    if (m_ack[1]) ack1_cnt++;
    if (s_stb && !s_stall) acc_cnt++;
    // Predict the owner/count seen after the coming rising edge.
    if (rst_n) begin
      if (owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          idx = (mlast + k) % NM;
          if (owner < 0 && m_cyc[idx]) begin
            owner = idx;
            mlast = idx;
            mcnt  = 0;
          end
        end
      end else if (!m_cyc[owner]) begin
        owner = -1;
        mcnt  = 0;
      end else begin
        mcnt = mcnt + ((e_stb && !s_stall) ? 1 : 0) - ((s_ack && mcnt > 0) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_we[m]  = we;
    m_adr[m*AW +: AW]   = adr;
    m_dat_m[m*DW +: DW] = dat;
  endtask

  task automatic do_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_stall = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int a0, a1, s0;

    // 1: single master, three pipelined strobes acked one cycle later
    do_reset();
    a0 = ack0_cnt; a1 = ack1_cnt; s0 = acc_cnt;
    set_m(0, 1, 0, 0, 16'h0, 16'h0);
    settle();
    chk("t1_gnt_idle", 32'(gnt), 32'h0);
    chk("t1_stall_idle", 32'(m_stall), 32'h3);
    step(); set_m(0, 1, 1, 1, 16'h1000, 16'hA000); settle();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_s_stb", 32'(s_stb), 32'h1);
    chk("t1_s_adr", 32'(s_adr), 32'h1000);
    step(); set_m(0, 1, 1, 1, 16'h1001, 16'hA001); s_ack = 1'b1; settle();
    chk("t1_ack", 32'(m_ack), 32'h1);
    step(); set_m(0, 1, 1, 1, 16'h1002, 16'hA002); settle();
    step(); set_m(0, 1, 0, 0, 16'h0, 16'h0); settle();
    step(); set_m(0, 0, 0, 0, 16'h0, 16'h0); s_ack = 1'b0; settle();
    step(); settle();
    chk("t1_acks_m0", 32'(ack0_cnt - a0), 32'd3);
    chk("t1_acks_m1", 32'(ack1_cnt - a1), 32'd0);
    chk("t1_accepts", 32'(acc_cnt - s0), 32'd3);
    chk("t1_gnt_end", 32'(gnt), 32'h0);

    // 2: simultaneous requests, round robin on release
    do_reset();
    set_m(0, 1, 0, 0, 16'h0, 16'h0); set_m(1, 1, 0, 0, 16'h0, 16'h0); settle();
    step(); settle();
    chk("t2_gnt_m0", 32'(gnt), 32'h1);
    set_m(0, 0, 0, 0, 16'h0, 16'h0);
    step(); settle();
    chk("t2_gap", 32'(gnt), 32'h0);
    step(); settle();
    chk("t2_gnt_m1", 32'(gnt), 32'h2);
    set_m(1, 0, 0, 0, 16'h0, 16'h0); set_m(0, 1, 0, 0, 16'h0, 16'h0);
    step(); set_m(1, 1, 0, 0, 16'h0, 16'h0); settle();
    chk("t2_gap2", 32'(gnt), 32'h0);
    step(); settle();
    chk("t2_gnt_rr", 32'(gnt), 32'h1);
    m_cyc = '0;
    step();

    // 3: outstanding limit, one ack frees a slot
    do_reset();
    set_m(0, 1, 0, 0, 16'h0, 16'h0);
    step(); set_m(0, 1, 1, 0, 16'h2000, 16'h0); s0 = acc_cnt;
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("t3_accepts", 32'(acc_cnt - s0), 32'd4);
    chk("t3_stb_full", 32'(s_stb), 32'h0);
    chk("t3_stall_full", 32'(m_stall), 32'h3);
    s_ack = 1'b1;
    step(); s_ack = 1'b0; settle();
    chk("t3_stb_5th", 32'(s_stb), 32'h1);
    chk("t3_stall_5th", 32'(m_stall), 32'h2);
    step(); set_m(0, 0, 0, 0, 16'h0, 16'h0);
    step(); step();

    // 4: slave stall while master 1 owns the bus
    do_reset();
    s_dat_s = 16'hC3C3;
    set_m(1, 1, 0, 0, 16'h0, 16'h0);
    step(); settle();
    chk("t4_gnt_m1", 32'(gnt), 32'h2);
    set_m(1, 1, 1, 1, 16'h3000, 16'hBEEF); s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_stall", 32'(m_stall), 32'h3);
      chk("t4_stb_held", 32'(s_stb), 32'h1);
      step();
    end
    s_stall = 1'b0; settle();
    chk("t4_stall_rel", 32'(m_stall), 32'h1);
    chk("t4_dat_m", 32'(s_dat_m), 32'hBEEF);
    step(); set_m(1, 1, 0, 0, 16'h0, 16'h0); s_ack = 1'b1; settle();
    chk("t4_ack_m1", 32'(m_ack), 32'h2);
    chk("t4_dat_s", 32'(m_dat_s), 32'hC3C3);
    step(); s_ack = 1'b0; set_m(1, 0, 0, 0, 16'h0, 16'h0);
    step(); step();

    // 5: abort with two strobes outstanding, late acks discarded
    do_reset();
    set_m(0, 1, 0, 0, 16'h0, 16'h0); set_m(1, 1, 0, 0, 16'h0, 16'h0);
    step(); set_m(0, 1, 1, 0, 16'h4000, 16'h0);
    step(); set_m(0, 1, 1, 0, 16'h4001, 16'h0);
    step(); set_m(0, 0, 0, 0, 16'h0, 16'h0); s_ack = 1'b1; settle();
    chk("t5_late1", 32'(m_ack), 32'h0);
    chk("t5_scyc", 32'(s_cyc), 32'h0);
    step(); settle();
    chk("t5_late2", 32'(m_ack), 32'h0);
    chk("t5_idle", 32'(gnt), 32'h0);
    step(); s_ack = 1'b0; set_m(1, 1, 1, 0, 16'h4100, 16'h0); settle();
    chk("t5_gnt_m1", 32'(gnt), 32'h2);
    chk("t5_stb_m1", 32'(s_stb), 32'h1);
    chk("t5_stall_m1", 32'(m_stall), 32'h1);
    step(); set_m(1, 0, 0, 0, 16'h0, 16'h0);
    step(); step();

    // 6: asynchronous reset in the middle of a burst
    do_reset();
    set_m(0, 1, 0, 0, 16'h0, 16'h0);
    step(); set_m(0, 1, 1, 1, 16'h6000, 16'h1234);
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_scyc", 32'(s_cyc), 32'h0);
    chk("t6_stall", 32'(m_stall), 32'h3);
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_stb", 32'(s_stb), 32'h0);
    step();
    rst_n = 1'b1;
    set_m(0, 1, 0, 0, 16'h0, 16'h0); set_m(1, 1, 0, 0, 16'h0, 16'h0); settle();
    chk("t6_idle", 32'(gnt), 32'h0);
    step(); settle();
    chk("t6_gnt_m0", 32'(gnt), 32'h1);
    m_cyc = '0; m_stb = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
